// File: rtl/relu_maxpool_stream.sv
// Streaming 1-D max-pool over ReLU outputs: one maximum per POOL samples or per in_last-terminated window.
// Optional RELU_MAXPOOL_ARGMAX_EN adds out_idx, the in-window position of the winning sample.
module relu_maxpool_stream #(
    parameter int WIDTH = 16,
    parameter int POOL  = 4,
    localparam int CW   = (POOL > 1) ? $clog2(POOL) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_partial
`ifdef RELU_MAXPOOL_ARGMAX_EN
    ,
    output logic [CW-1:0]    out_idx
`endif
);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] next_max;
    logic             accept;
    logic             last_slot;
    logic             close_win;
    logic             greater;
`ifdef RELU_MAXPOOL_ARGMAX_EN
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    next_idx;
`endif

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_slot = (count == CW'(POOL - 1));
    assign close_win = accept && (last_slot || in_last);

    // Negative inputs (including -0) collapse to +0, so only magnitude bits matter afterwards.
    assign norm    = in_data[WIDTH-1] ? '0 : in_data;
    // Strict compare: on ties the earlier sample stays the winner.
    assign greater = (norm[WIDTH-2:0] > max_q[WIDTH-2:0]);

    // NOTE: every combinational output gets an unconditional default first so no latch is inferred.
    always_comb begin
        next_max = max_q;
        if (count == '0 || greater) begin
            next_max = norm;
        end
    end

`ifdef RELU_MAXPOOL_ARGMAX_EN
    always_comb begin
        next_idx = idx_q;
        if (count == '0) begin
            next_idx = '0;
        end else if (greater) begin
            next_idx = count;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            max_q       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_partial <= 1'b0;
        end else begin
            if (close_win) begin
                count       <= '0;
                max_q       <= '0;
                out_data    <= next_max;
                out_partial <= !last_slot;
                out_valid   <= 1'b1;
            end else begin
                if (accept) begin
                    count <= count + CW'(1);
                    max_q <= next_max;
                end
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef RELU_MAXPOOL_ARGMAX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            out_idx <= '0;
        end else if (close_win) begin
            idx_q   <= '0;
            out_idx <= next_idx;
        end else if (accept) begin
            idx_q <= next_idx;
        end
    end
`endif

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Scoreboard bench for relu_maxpool_stream (POOL=4, WIDTH=16); honours RELU_MAXPOOL_ARGMAX_EN when defined.
module tb_relu_maxpool_stream;

    typedef struct {
        logic [15:0] data;
        logic        partial;
        logic [1:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_partial;
`ifdef RELU_MAXPOOL_ARGMAX_EN
    logic [1:0]  out_idx;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    relu_maxpool_stream #(.WIDTH(16), .POOL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_partial(out_partial)
`ifdef RELU_MAXPOOL_ARGMAX_EN
        ,
        .out_idx    (out_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [15:0] d, input logic p, input logic [1:0] i);
        exp_t e;
        e.data = d;
        e.partial = p;
        e.idx = i;
        sb.push_back(e);
    endtask

    // Presents one sample, waits (bounded) for in_ready, returns 1 time unit after the accepting edge.
    task automatic send(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for sample 0x%0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: every consumed result is compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got data 0x%0h with empty scoreboard", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_partial", 32'(out_partial), 32'(e.partial));
`ifdef RELU_MAXPOOL_ARGMAX_EN
                    check("out_idx", 32'(out_idx), 32'(e.idx));
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_partial", 32'(out_partial), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic window with latency check
        expect_out(16'h4000, 1'b0, 2'd1);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h3E00, 1'b0);
        check("pre_close_valid", 32'(out_valid), 32'd0);
        send(16'h3800, 1'b0);
        check("latency_valid", 32'(out_valid), 32'd1);

        // All negative inputs collapse to +0
        expect_out(16'h0000, 1'b0, 2'd0);
        send(16'h8000, 1'b0);
        send(16'hC000, 1'b0);
        send(16'h8000, 1'b0);
        send(16'hBC00, 1'b0);

        // Large-magnitude negative must not beat small positives
        expect_out(16'h3000, 1'b0, 2'd1);
        send(16'hFC00, 1'b0);
        send(16'h3000, 1'b0);
        send(16'hC400, 1'b0);
        send(16'h2C00, 1'b0);

        // Early close, then a fresh window
        expect_out(16'h4200, 1'b1, 2'd1);
        send(16'h3C00, 1'b0);
        send(16'h4200, 1'b1);
        expect_out(16'h3800, 1'b0, 2'd0);
        repeat (4) send(16'h3800, 1'b0);

        // in_last on first sample, then in_last on a full window
        expect_out(16'h5000, 1'b1, 2'd0);
        send(16'h5000, 1'b1);
        expect_out(16'h4000, 1'b0, 2'd3);
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);

        // Ties and NaN
        expect_out(16'h7E00, 1'b0, 2'd2);
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h7E00, 1'b0);
        send(16'h3C00, 1'b0);
        expect_out(16'h4000, 1'b0, 2'd0);
        repeat (4) send(16'h4000, 1'b0);

        // Backpressure: result held for 10 cycles
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_out(16'h4400, 1'b0, 2'd0);
        send(16'h4400, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_data", 32'(out_data), 32'h4400);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("consumed_valid", 32'(out_valid), 32'd0);

        // Reset mid-window discards the partial window
        send(16'h7000, 1'b0);
        send(16'h6000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_out(16'h3800, 1'b0, 2'd0);
        send(16'h3800, 1'b0);
        send(16'h3000, 1'b0);
        send(16'h3400, 1'b0);
        send(16'h2000, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relu_maxpool_stream.md
Name: relu_maxpool_stream

Overview:
- Streaming 1-D max-pool stage directly downstream of the ReLU stage.
- Consumes WIDTH-bit IEEE-754-style words (sign in bit WIDTH-1) over a valid/ready handshake.
- Emits one maximum per window of POOL consecutive accepted samples; a frame-end marker closes a window early.
- Results feed the next layer's input buffer.

Parameters:
- WIDTH, 16: sample width; bit WIDTH-1 is the sign, bits WIDTH-2:0 are exponent|mantissa.
- POOL, 4: window length in samples; legal range 1..256.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream sample valid.
- in_ready, output, 1: block can accept a sample this cycle.
- in_data, input, WIDTH: sample.
- in_last, input, 1: sample is last of frame; closes the current window.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, WIDTH: window maximum.
- out_partial, output, 1: window closed by in_last with fewer than POOL samples.

Behaviour:
- Reset and clocking:
  - One clock; reset is asynchronous and active-low (rst_n), applied to all state.
  - Reset values: out_valid=0, out_data=0, out_partial=0, window count=0, running max=0.
  - in_ready is combinational: in_ready = !out_valid || out_ready. Its value after reset is therefore 1.
  - Reset mid-window discards the partial window; no output is produced for it.
- Handshakes:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
- Sample normalisation:
  - Any input with sign=1 (including -0 = 0x8000, which the ReLU stage produces for negatives) is treated as +0 (all zeros).
  - Samples with sign=0 pass unchanged.
- Comparison:
  - Unsigned compare on bits WIDTH-2:0 of normalised values. This is exact ordering for non-negative IEEE values.
  - A positive NaN compares greatest and propagates.
  - Ties keep the earlier sample.
- Window state:
  - State is a count 0..POOL-1 plus a running-max register.
  - When count==0, the accepted sample initialises the max; otherwise max <= greater(max, sample).
- Window close and output:
  - The window closes on the accepted sample that makes count reach POOL, or on an accepted sample with in_last=1, whichever comes first.
  - On close: out_data <= final max (sign bit always 0); out_partial <= (samples in window < POOL); out_valid <= 1; count <= 0.
  - Latency: result is valid the cycle after the closing sample is accepted.
  - At full rate (out_ready held 1), throughput is 1 sample/cycle.
- Stalls:
  - While out_valid && !out_ready, out_data and out_partial are held stable and in_ready=0.
  - Output consumption and closing of a new window in the same cycle are allowed: out_valid stays 1 with the new data.
  - Output consumption with no new close clears out_valid.
- Special cases:
  - POOL=1: every sample passes through normalised with 1-cycle latency; out_partial is always 0.
  - in_last on a sample that also completes a full window: out_partial=0.
  - in_last never produces an empty window. A frame with in_last on the first sample gives a 1-sample result with out_partial=1 when POOL>1.

Optional Feature:
- Macro: RELU_MAXPOOL_ARGMAX_EN.
- Defined: adds output out_idx, width clog2(POOL) (min 1). It carries the 0-based position within the window of the winning sample, under the same tie rule (earliest wins). It is registered with out_data, has reset value 0, and is held during stall.
- Undefined: port and index logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic window: POOL=4, out_ready=1, feed 0x3C00, 0x4000, 0x3E00, 0x3800 -> one output 0x4000, out_partial=0, valid 1 cycle after 4th accept; argmax build gives out_idx=1.
- All negative: feed 0x8000, 0xC000, 0x8000, 0xBC00 -> out_data=0x0000, sign bit 0.
- Early close: feed 0x3C00 then 0x4200 with in_last=1 -> out_data=0x4200, out_partial=1; the next window starts fresh (next 4 samples 0x3800 each -> 0x3800).
- Backpressure: hold out_ready=0 after a result -> in_ready=0, out_data stable for 10 cycles; raise out_ready -> consumed, in_ready=1 the same cycle.
- Ties and NaN: feed 0x4000, 0x4000, 0x7E00, 0x3C00 -> out_data=0x7E00 (NaN propagates, out_idx=2); then feed 0x4000 x4 -> out_idx=0.
- Reset mid-window: accept 2 samples, pulse rst_n low asynchronously -> out_valid=0 immediately; the next 4 samples form a complete window with no stale max.
